// File: rtl/spi_cmd_blink_ctrl.sv
`timescale 1ns/1ps
// SPI command decoder: moves receiver bytes into i_clk, decodes 2-byte write frames into
// control/period registers and drives a prescaled LED blink generator from them.
module spi_cmd_blink_ctrl #(
   parameter int          SYNC_STAGES = 2,
   parameter int          PRESCALE    = 1000,
   parameter logic [15:0] PERIOD_RST  = 16'd500
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_spi_cs_n,
   input  logic        i_rx_done,
   input  logic [7:0]  i_rx_data,
   output logic        o_led,
   output logic        o_blink_en,
   output logic [15:0] o_period,
   output logic [7:0]  o_err_cnt,
   output logic        o_busy
);
   // state | meaning
   // IDLE  | waiting for the command byte of a frame
   // DATA  | valid write command latched, waiting for its data byte
   // SKIP  | frame consumed or rejected, ignore bytes until CS rises
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      SKIP = 2'd2
   } state_t;

   localparam int PS_W = $clog2(PRESCALE);

   logic [SYNC_STAGES-1:0] r_done_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic                   r_done_q;
   logic                   r_cs_q;
   logic                   w_strb;
   logic                   w_fend;
   logic                   r_strb;
   logic                   r_fend;
   logic [7:0]             r_byte;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic                   w_addr_ld;
   logic                   w_wr_en;
   logic                   w_err_inc;
   logic [1:0]             r_addr;

   logic [2:0]             r_ctrl;
   logic [15:0]            r_period;
   logic [7:0]             r_err_cnt;

   logic [PS_W-1:0]        r_presc;
   logic [15:0]            r_tick_cnt;
   logic                   r_led;
   logic                   w_tick;
   logic [15:0]            w_per_eff;
   logic                   w_wrap;

   // CS idles high, so its synchroniser resets to 1 to avoid a false frame end after reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_done_sync <= '0;
         r_cs_sync   <= '1;
         r_done_q    <= 1'b0;
         r_cs_q      <= 1'b1;
      end else begin
         r_done_sync <= {r_done_sync[SYNC_STAGES-2:0], i_rx_done};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
         r_done_q    <= r_done_sync[SYNC_STAGES-1];
         r_cs_q      <= r_cs_sync[SYNC_STAGES-1];
      end
   end

   assign w_strb = r_done_sync[SYNC_STAGES-1] & ~r_done_q;
   assign w_fend = r_cs_sync[SYNC_STAGES-1] & ~r_cs_q;

   // Frame end is delayed alongside the strobe so both reach the FSM in matching cycles
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_strb <= 1'b0;
         r_fend <= 1'b0;
         r_byte <= 8'h00;
      end else begin
         r_strb <= w_strb;
         r_fend <= w_fend;
         if (w_strb) begin
            r_byte <= i_rx_data;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_addr_ld   = 1'b0;
      w_wr_en     = 1'b0;
      w_err_inc   = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_strb) begin
               if (r_byte[7] && (r_byte[3:0] <= 4'd2)) begin
                  w_addr_ld   = 1'b1;
                  w_state_nxt = DATA;
               end else begin
                  w_err_inc   = 1'b1;
                  w_state_nxt = SKIP;
               end
            end
         end
         DATA: begin
            if (r_strb) begin
               w_wr_en     = 1'b1;
               w_state_nxt = SKIP;
            end else if (r_fend) begin
               w_err_inc   = 1'b1;
            end
         end
         SKIP: begin
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      if (r_fend) begin
         w_state_nxt = IDLE;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr    <= 2'd0;
         r_ctrl    <= 3'd0;
         r_period  <= PERIOD_RST;
         r_err_cnt <= 8'h00;
      end else begin
         if (w_addr_ld) begin
            r_addr <= r_byte[1:0];
         end
         if (w_wr_en) begin
            case (r_addr)
               2'd0:    r_ctrl          <= r_byte[2:0];
               2'd1:    r_period[7:0]   <= r_byte;
               2'd2:    r_period[15:8]  <= r_byte;
               default: r_ctrl          <= r_ctrl;
            endcase
         end
         if (w_err_inc && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   assign w_tick    = r_ctrl[0] && (r_presc == PS_W'(PRESCALE - 1));
   assign w_per_eff = (r_period == 16'd0) ? 16'd1 : r_period;
   // >= rather than == so a period lowered below the running count still wraps promptly
   assign w_wrap    = ({1'b0, r_tick_cnt} + 17'd1) >= {1'b0, w_per_eff};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_presc    <= '0;
         r_tick_cnt <= 16'd0;
         r_led      <= 1'b0;
      end else if (!r_ctrl[0]) begin
         r_presc    <= '0;
         r_tick_cnt <= 16'd0;
         r_led      <= 1'b0;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
         if (w_tick) begin
            if (w_wrap) begin
               r_tick_cnt <= 16'd0;
               r_led      <= ~r_led;
            end else begin
               r_tick_cnt <= r_tick_cnt + 16'd1;
            end
         end
      end
   end

   assign o_led      = r_ctrl[2] ? r_ctrl[1] : r_led;
   assign o_blink_en = r_ctrl[0];
   assign o_period   = r_period;
   assign o_err_cnt  = r_err_cnt;
   assign o_busy     = (r_state != IDLE);

endmodule
